// File: rtl/ai_policy_scheduler_if.sv
// Policy ROM read port shared by the AI scheduler (master) and the ROM (slave).
// The scheduler drives the read strobe and address; the ROM returns move codes.
interface ai_policy_scheduler_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 2
);

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output mem_en,
    output mem_addr,
    input  mem_dout
  );

  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_dout
  );

endinterface : ai_policy_scheduler_if

// File: rtl/ai_policy_scheduler.sv
// ai_policy_scheduler: time-shares one single-port policy ROM between two AI
// players. Each accepted frame tick snapshots both state addresses, performs
// one ROM lookup per requesting player and holds each player's action until
// its next lookup. Player order alternates between frames that serve both.
// Optional feature macro: AI_OVERRUN_CNT_EN adds the saturating overrun_cnt
// output; without it the port and counter are absent.
module ai_policy_scheduler #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 2,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   frame_tick,
  input  logic [1:0]             req,
  input  logic [ADDR_W-1:0]      addr0,
  input  logic [ADDR_W-1:0]      addr1,
  ai_policy_scheduler_if.master  rom,
  output logic [2:0]             action0,
  output logic [2:0]             action1,
  output logic [1:0]             act_valid,
  output logic                   busy,
  output logic                   overrun
`ifdef AI_OVERRUN_CNT_EN
  ,
  output logic [7:0]             overrun_cnt
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ACT_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // registered state and outputs
  logic [1:0]        state_q,     state_d;
  logic [1:0]        pend_q,      pend_d;
  logic [ADDR_W-1:0] snap0_q,     snap0_d;
  logic [ADDR_W-1:0] snap1_q,     snap1_d;
  logic              sel_q,       sel_d;
  logic              both_q,      both_d;
  logic              rr_q,        rr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              mem_en_q,    mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [ACT_W-1:0]  action0_q,   action0_d;
  logic [ACT_W-1:0]  action1_q,   action1_d;
  logic [1:0]        act_valid_q, act_valid_d;
  logic              busy_q,      busy_d;
  logic              overrun_q,   overrun_d;

  logic              tick_ok;
  logic              first_sel;
  logic [DATA_W:0]   dout_ext;
  logic [ACT_W-1:0]  action_new;

  // move code 0..3 maps to action 1..4; 0 is reserved for "no move"
  always_comb begin
    dout_ext   = {1'b0, rom.mem_dout};
    action_new = ACT_W'(dout_ext) + 3'd1;
  end

  // first player of a frame: the lone requester, or rr when both request
  always_comb begin
    first_sel = rr_q;
    if (req == 2'b01) begin
      first_sel = 1'b0;
    end else if (req == 2'b10) begin
      first_sel = 1'b1;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    snap0_d     = snap0_q;
    snap1_d     = snap1_q;
    sel_d       = sel_q;
    both_d      = both_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    action0_d   = action0_q;
    action1_d   = action1_q;
    act_valid_d = 2'b00;
    overrun_d   = 1'b0;
    tick_ok     = frame_tick & en;

    case (state_q)
      ST_IDLE: begin
        if (tick_ok) begin
          pend_d  = req;
          snap0_d = addr0;
          snap1_d = addr1;
          both_d  = &req;
          if (req != 2'b00) begin
            state_d    = ST_ISSUE;
            sel_d      = first_sel;
            mem_en_d   = 1'b1;
            mem_addr_d = first_sel ? addr1 : addr0;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = CNT_W'(RD_LAT);
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (sel_q) begin
            action1_d = action_new;
          end else begin
            action0_d = action_new;
          end
          pend_d[sel_q]      = 1'b0;
          act_valid_d[sel_q] = 1'b1;
          if (pend_q[~sel_q]) begin
            state_d    = ST_ISSUE;
            sel_d      = ~sel_q;
            mem_en_d   = 1'b1;
            mem_addr_d = sel_q ? snap0_q : snap1_q;
          end else begin
            state_d = ST_IDLE;
            if (both_q) begin
              rr_d = ~rr_q;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // a tick arriving mid-frame is dropped and flagged, never queued
    if ((state_q != ST_IDLE) && tick_ok) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 2'b00;
      snap0_q     <= '0;
      snap1_q     <= '0;
      sel_q       <= 1'b0;
      both_q      <= 1'b0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      action0_q   <= 3'd0;
      action1_q   <= 3'd0;
      act_valid_q <= 2'b00;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      snap0_q     <= snap0_d;
      snap1_q     <= snap1_d;
      sel_q       <= sel_d;
      both_q      <= both_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      action0_q   <= action0_d;
      action1_q   <= action1_d;
      act_valid_q <= act_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef AI_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_q;

  // saturating count of dropped ticks, updated together with the overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt_q <= 8'd0;
    end else if (overrun_d && (overrun_cnt_q != 8'hFF)) begin
      overrun_cnt_q <= overrun_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt = overrun_cnt_q;
`endif

  assign rom.mem_en   = mem_en_q;
  assign rom.mem_addr = mem_addr_q;
  assign action0      = action0_q;
  assign action1      = action1_q;
  assign act_valid    = act_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule : ai_policy_scheduler
